// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALUOp and mux selects.
// ALUOp codes are also consumed by ALU_Control and its bench.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StRWb     = 4'd4,
    StIWb     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StHalt    = 4'd12
  } state_e;

  localparam logic [3:0] OpRtype = 4'h0;
  localparam logic [3:0] OpShift = 4'h1;
  localparam logic [3:0] OpAddi  = 4'h2;
  localparam logic [3:0] OpAndi  = 4'h3;
  localparam logic [3:0] OpOri   = 4'h4;
  localparam logic [3:0] OpSlti  = 4'h5;
  localparam logic [3:0] OpLui   = 4'h6;
  localparam logic [3:0] OpLw    = 4'h7;
  localparam logic [3:0] OpSw    = 4'h8;
  localparam logic [3:0] OpBeq   = 4'h9;
  localparam logic [3:0] OpBne   = 4'hA;
  localparam logic [3:0] OpJ     = 4'hB;
  localparam logic [3:0] OpJal   = 4'hC;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [2:0] AluRtype = 3'd0;
  localparam logic [2:0] AluShift = 3'd1;
  localparam logic [2:0] AluAdd   = 3'd2;
  localparam logic [2:0] AluSub   = 3'd3;
  localparam logic [2:0] AluAnd   = 3'd4;
  localparam logic [2:0] AluOr    = 3'd5;
  localparam logic [2:0] AluSlt   = 3'd6;
  localparam logic [2:0] AluPassb = 3'd7;

  localparam logic [1:0] SrcBReg    = 2'd0;
  localparam logic [1:0] SrcBConst2 = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh  = 2'd3;

  localparam logic [1:0] PcAlu    = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcJump   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  // Successor of DECODE; StFetch doubles as the undefined-opcode marker.
  function automatic state_e decode_next(input logic [3:0] op);
    case (op)
      OpRtype, OpShift:                    return StExecR;
      OpAddi, OpAndi, OpOri, OpSlti, OpLui: return StExecI;
      OpLw, OpSw:                          return StMemAddr;
      OpBeq, OpBne:                        return StBranch;
      OpJ, OpJal:                          return StJump;
      OpHalt:                              return StHalt;
      default:                             return StFetch;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AOPW = 3
) ();
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;
  logic            PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic            IRWrite, MemtoReg, RegWrite, ALUSrcA, RegDst;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSource;
  logic [AOPW-1:0] ALUOp;
  logic            halted;
  logic            illegal;
  logic [3:0]      state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
           ALUSrcA, RegDst, ALUSrcB, PCSource, ALUOp, halted, illegal, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
           ALUSrcA, RegDst, ALUSrcB, PCSource, ALUOp, halted, illegal, state_dbg
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode: (state, opcode, zero, mem_ready) -> control vector.
module mc_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  state_e         state,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SrcBConst2;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_source = PcAlu;
        // PC advances only on the cycle the fetch completes.
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = SrcBImmSh;
        ctrl.alu_op    = AluAdd;
        ctrl.illegal   = (decode_next(opcode) == StFetch);
      end
      StExecR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = (opcode == OpShift) ? AluShift : AluRtype;
      end
      StRWb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      StExecI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        case (opcode)
          OpAndi:  ctrl.alu_op = AluAnd;
          OpOri:   ctrl.alu_op = AluOr;
          OpSlti:  ctrl.alu_op = AluSlt;
          OpLui:   ctrl.alu_op = AluPassb;
          default: ctrl.alu_op = AluAdd;
        endcase
      end
      StIWb: ctrl.reg_write = 1'b1;
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StMemWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBReg;
        ctrl.alu_op        = AluSub;
        ctrl.pc_source     = PcAluOut;
        ctrl.pc_write_cond = (opcode == OpBeq);
        ctrl.pc_write      = (opcode == OpBne) & ~zero;
      end
      StJump: begin
        ctrl.pc_source = PcJump;
        ctrl.pc_write  = 1'b1;
        ctrl.reg_write = (opcode == OpJal);
      end
      StHalt:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: state register and next-state logic; outputs come from
// mc_ctrl_decode and are forced low while Reset is asserted.
module mc_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned AOPW = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  mc_control_fsm_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = bus.mem_ready ? StDecode : StFetch;
      StDecode:  state_d = decode_next(bus.opcode);
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemAddr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   state_d = bus.mem_ready ? StMemWb : StMemRd;
      StMemWr:   state_d = bus.mem_ready ? StFetch : StMemWr;
      StRWb, StIWb, StMemWb, StBranch, StJump: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
  end

  mc_ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign ctrl_g = Reset ? '0 : ctrl;

  assign bus.PCWrite     = ctrl_g.pc_write;
  assign bus.PCWriteCond = ctrl_g.pc_write_cond;
  assign bus.IorD        = ctrl_g.iord;
  assign bus.MemRead     = ctrl_g.mem_read;
  assign bus.MemWrite    = ctrl_g.mem_write;
  assign bus.IRWrite     = ctrl_g.ir_write;
  assign bus.MemtoReg    = ctrl_g.mem_to_reg;
  assign bus.RegWrite    = ctrl_g.reg_write;
  assign bus.ALUSrcA     = ctrl_g.alu_src_a;
  assign bus.RegDst      = ctrl_g.reg_dst;
  assign bus.ALUSrcB     = ctrl_g.alu_src_b;
  assign bus.PCSource    = ctrl_g.pc_source;
  assign bus.ALUOp       = AOPW'(ctrl_g.alu_op);
  assign bus.halted      = ctrl_g.halted;
  assign bus.illegal     = ctrl_g.illegal;
  assign bus.state_dbg   = Reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: opcode table, directed corner cases and randomized instruction
// streams checked against per-instruction cycle/enable counts.
module tb_mc_control_fsm;
  import cpu_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    bit pcw, pcwc, rw, rdst, rd, wr, iord, m2r, ill;
    int alu;
  } obs_t;
  obs_t tr[$];

  typedef struct {
    logic [3:0] op;
    int         exp_st;
    int         exp_alu;
    bit         alu_care;
    bit         exp_ill;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle(input logic mr);
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    tick();
    Reset = 1'b0;
  endtask

  function automatic int all_outs();
    return int'({bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.RegDst,
                 bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.halted, bus.illegal,
                 bus.state_dbg});
  endfunction

  // Runs one instruction from the start of its fetch; wf/wm are wait cycles before the
  // fetch and the data access complete. Expected totals follow from the instruction class.
  task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm);
    int   body, len, mem_done;
    int   n_pcw, n_pcwc, n_rw, n_rd, n_wr, n_iord, n_ill;
    bit   is_lw, is_sw, is_jmp;
    logic mr;
    obs_t o;
    is_lw  = (op == 4'd7);
    is_sw  = (op == 4'd8);
    is_jmp = (op == 4'd11) || (op == 4'd12);
    if (op <= 4'd6)       body = 3;
    else if (is_lw)       body = 4 + wm;
    else if (is_sw)       body = 3 + wm;
    else if (op <= 4'd12) body = 2;
    else                  body = 1;
    len      = wf + 1 + body;
    mem_done = wf + 3 + wm;
    bus.opcode = op;
    bus.zero   = z;
    tr.delete();
    for (int i = 0; i < len; i++) begin
      if (i <= wf) mr = (i == wf);
      else if ((is_lw || is_sw) && i >= wf + 3 && i <= mem_done) mr = (i == mem_done);
      else mr = 1'($urandom_range(0, 1));
      settle(mr);
      o.st = int'(bus.state_dbg);
      o.pcw = bus.PCWrite; o.pcwc = bus.PCWriteCond; o.rw = bus.RegWrite;
      o.rdst = bus.RegDst; o.rd = bus.MemRead; o.wr = bus.MemWrite; o.iord = bus.IorD;
      o.m2r = bus.MemtoReg; o.ill = bus.illegal; o.alu = int'(bus.ALUOp);
      tr.push_back(o);
      tick();
    end
    #1;
    check("end_in_fetch", int'(bus.state_dbg), 0);
    n_pcw = 0; n_pcwc = 0; n_rw = 0; n_rd = 0; n_wr = 0; n_iord = 0; n_ill = 0;
    foreach (tr[k]) begin
      n_pcw += int'(tr[k].pcw);  n_pcwc += int'(tr[k].pcwc); n_rw += int'(tr[k].rw);
      n_rd  += int'(tr[k].rd);   n_wr   += int'(tr[k].wr);   n_iord += int'(tr[k].iord);
      n_ill += int'(tr[k].ill);
    end
    check("pcwrite_cnt", n_pcw, 1 + int'(op == 4'd10 && !z) + int'(is_jmp));
    check("pcwritecond_cnt", n_pcwc, int'(op == 4'd9));
    check("regwrite_cnt", n_rw, int'(op <= 4'd7 || op == 4'd12));
    check("memread_cnt", n_rd, wf + 1 + (is_lw ? wm + 1 : 0));
    check("memwrite_cnt", n_wr, is_sw ? wm + 1 : 0);
    check("iord_cnt", n_iord, (is_lw || is_sw) ? wm + 1 : 0);
    check("illegal_cnt", n_ill, int'(op == 4'd13 || op == 4'd14));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[16];
    int   n;
    Reset = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    #1;
    check("reset_all_zero", all_outs(), 0);
    tick();
    Reset = 1'b0;
    settle(1'b1);
    check("rel_state", int'(bus.state_dbg), 0);
    check("rel_memread", int'(bus.MemRead), 1);
    check("rel_irwrite", int'(bus.IRWrite), 1);
    check("rel_pcwrite", int'(bus.PCWrite), 1);
    check("rel_aluop", int'(bus.ALUOp), 2);
    tick();
    settle(1'b0);
    check("rel_decode", int'(bus.state_dbg), 1);

    // Opcode table: state and ALUOp one cycle after DECODE, illegal pulse in DECODE.
    vecs[0]  = '{4'd0,  2,  0, 1'b1, 1'b0};
    vecs[1]  = '{4'd1,  2,  1, 1'b1, 1'b0};
    vecs[2]  = '{4'd2,  3,  2, 1'b1, 1'b0};
    vecs[3]  = '{4'd3,  3,  4, 1'b1, 1'b0};
    vecs[4]  = '{4'd4,  3,  5, 1'b1, 1'b0};
    vecs[5]  = '{4'd5,  3,  6, 1'b1, 1'b0};
    vecs[6]  = '{4'd6,  3,  7, 1'b1, 1'b0};
    vecs[7]  = '{4'd7,  6,  2, 1'b1, 1'b0};
    vecs[8]  = '{4'd8,  6,  2, 1'b1, 1'b0};
    vecs[9]  = '{4'd9,  10, 3, 1'b1, 1'b0};
    vecs[10] = '{4'd10, 10, 3, 1'b1, 1'b0};
    vecs[11] = '{4'd11, 11, 0, 1'b0, 1'b0};
    vecs[12] = '{4'd12, 11, 0, 1'b0, 1'b0};
    vecs[13] = '{4'd13, 0,  2, 1'b1, 1'b1};
    vecs[14] = '{4'd14, 0,  2, 1'b1, 1'b1};
    vecs[15] = '{4'd15, 12, 0, 1'b0, 1'b0};
    foreach (vecs[i]) begin
      do_reset();
      bus.opcode = vecs[i].op;
      settle(1'b1);
      tick();
      settle(1'b0);
      check($sformatf("tbl_ill_op%0d", i), int'(bus.illegal), int'(vecs[i].exp_ill));
      tick();
      settle(1'b0);
      check($sformatf("tbl_state_op%0d", i), int'(bus.state_dbg), vecs[i].exp_st);
      check($sformatf("tbl_ill_after_op%0d", i), int'(bus.illegal), 0);
      if (vecs[i].alu_care)
        check($sformatf("tbl_aluop_op%0d", i), int'(bus.ALUOp), vecs[i].exp_alu);
    end

    // R-type walk.
    do_reset();
    run_instr(4'd0, 1'b0, 0, 0);
    check("r_len", tr.size(), 4);
    check("r_st1", tr[1].st, 1);
    check("r_st2", tr[2].st, 2);
    check("r_alu", tr[2].alu, 0);
    check("r_st3", tr[3].st, 4);
    check("r_wb", int'(tr[3].rw && tr[3].rdst), 1);

    // lw with three wait cycles on the data read.
    run_instr(4'd7, 1'b0, 0, 3);
    check("lw_len", tr.size(), 8);
    n = 0;
    for (int k = 3; k < 7; k++) n += int'(tr[k].rd && tr[k].iord && tr[k].st == 7);
    check("lw_rd_hold", n, 4);
    check("lw_wb_state", tr[7].st, 8);
    check("lw_wb", int'(tr[7].m2r && tr[7].rw), 1);

    // Branches.
    run_instr(4'd9, 1'b1, 0, 0);
    check("beq_pcwc", int'(tr[2].pcwc), 1);
    run_instr(4'd10, 1'b1, 0, 0);
    check("bne_z1_pcw", int'(tr[2].pcw), 0);
    run_instr(4'd10, 1'b0, 0, 0);
    check("bne_z0_pcw", int'(tr[2].pcw), 1);

    // Randomized instruction stream (HALT excluded).
    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // HALT is sticky until Reset.
    do_reset();
    bus.opcode = 4'd15;
    settle(1'b1);
    tick();
    settle(1'b1);
    tick();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      settle(1'($urandom_range(0, 1)));
      n += int'(bus.halted && bus.state_dbg == 4'd12 && !bus.PCWrite && !bus.MemRead);
      tick();
    end
    check("halt_held", n, 20);
    Reset = 1'b1;
    #1;
    check("halt_cleared", int'(bus.halted), 0);
    tick();
    Reset = 1'b0;
    #1;
    check("halt_rel_state", int'(bus.state_dbg), 0);
    check("halt_rel_memread", int'(bus.MemRead), 1);

    // Reset in the middle of a stalled store.
    do_reset();
    bus.opcode = 4'd8;
    settle(1'b1); tick();
    settle(1'b0); tick();
    settle(1'b0); tick();
    settle(1'b0);
    check("sw_wr_state", int'(bus.state_dbg), 9);
    check("sw_wr_active", int'(bus.MemWrite), 1);
    tick();
    settle(1'b0);
    check("sw_wr_held", int'(bus.MemWrite), 1);
    Reset = 1'b1;
    #1;
    check("sw_reset_memwrite", int'(bus.MemWrite), 0);
    check("sw_reset_iord", int'(bus.IorD), 0);
    tick();
    Reset = 1'b0;
    #1;
    check("sw_rel_state", int'(bus.state_dbg), 0);
    check("sw_rel_memwrite", int'(bus.MemWrite), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
